// File: rtl/fp_mult_approx_pipe.sv
// ---------------------------------------------------------------------------
// fp_mult_approx_pipe
//
// Pipelined approximate floating-point multiplier for IEEE-754-style words of
// width W = 1 + EXP_W + MAN_W. Before the multiply, the low TRUNC mantissa
// bits of each operand are forced to zero. Denormal inputs are flushed to
// zero. An all-ones exponent (Inf/NaN) on either operand yields a canonical
// qNaN.
//
// Timing: an operand pair accepted at edge N appears with out_valid at edge
// N+3, provided the pipeline is not stalled. The block accepts one operand
// pair per cycle. A stalled output freezes every stage, and bubbles travel
// with the data.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   operand-side handshake (in_ready = ~stall)
//   a_operand, b_operand  operands, W bits each
//   out_valid / out_ready result-side handshake
//   result                product, W bits
//   Exception             an operand had an all-ones exponent
//   Overflow              product exponent too large (or both operands Inf/NaN)
//   Underflow             product exponent below the minimum normal
//
// Optional feature macro: FPMULA_RNE_EN
//   Defined   -> round-to-nearest-even, using guard/sticky bits from the
//                discarded product bits.
//   Undefined -> pure truncation of the product.
// ---------------------------------------------------------------------------
module fp_mult_approx_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TRUNC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a_operand,
  input  logic [EXP_W+MAN_W:0] b_operand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 Exception,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int ES_W = EXP_W + 2;
`ifdef FPMULA_RNE_EN
  localparam int P_LO = 0;       // rounding needs every discarded bit
`else
  localparam int P_LO = MAN_W;   // truncation never looks below bit MAN_W
`endif
  localparam int PW = 2*MAN_W + 2 - P_LO;

  localparam logic [MAN_W-1:0]       KEEP_MASK = {MAN_W{1'b1}} << TRUNC;
  localparam logic signed [ES_W-1:0] BIAS      = ES_W'((1 << (EXP_W-1)) - 1);
  localparam logic signed [ES_W-1:0] ES_INF    = ES_W'((1 << EXP_W) - 1);
  localparam logic signed [ES_W-1:0] ES_ONE    = ES_W'(1);
  localparam logic signed [ES_W-1:0] ES_ZERO   = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: a result held at the output freezes the whole pipeline.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage 0: captured operands
  logic         v0_q;
  logic [W-1:0] a0_q, b0_q;

  // Stage 1: unpacked fields
  logic                   v1_q, s1_q, zero1_q, exc1_q, bexc1_q;
  logic signed [ES_W-1:0] es1_q;
  logic [MAN_W:0]         ma1_q, mb1_q;

  // Stage 2: raw mantissa product
  logic                   v2_q, s2_q, zero2_q, exc2_q, bexc2_q;
  logic signed [ES_W-1:0] es2_q;
  logic [2*MAN_W+1:P_LO]  p2_q;

  // Stage 3: registered outputs
  logic         out_valid_q, exc_q, ovf_q, unf_q;
  logic [W-1:0] result_q;

  // ---- S1 unpack (combinational from stage 0) ----
  logic [EXP_W-1:0]       ea, eb;
  logic                   s1_d, zero1_d, exc1_d, bexc1_d;
  logic signed [ES_W-1:0] es1_d;
  logic [MAN_W:0]         ma1_d, mb1_d;

  assign ea      = a0_q[W-2:MAN_W];
  assign eb      = b0_q[W-2:MAN_W];
  assign s1_d    = a0_q[W-1] ^ b0_q[W-1];
  assign exc1_d  = (&ea) | (&eb);
  assign bexc1_d = (&ea) & (&eb);
  assign zero1_d = (ea == '0) | (eb == '0);
  assign ma1_d   = {1'b1, a0_q[MAN_W-1:0] & KEEP_MASK};
  assign mb1_d   = {1'b1, b0_q[MAN_W-1:0] & KEEP_MASK};
  assign es1_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  // ---- S2 multiply: keep only the product bits that S3 will look at ----
  logic [PW-1:0] p2_d;
  assign p2_d = PW'(({{(MAN_W+1){1'b0}}, ma1_q} * {{(MAN_W+1){1'b0}}, mb1_q}) >> P_LO);

  // ---- S3 normalise / round / pack ----
  logic                   msb;
  logic signed [ES_W-1:0] es_n;
  logic [MAN_W-1:0]       mant;
  logic [W-1:0]           res_d;
  logic                   exc_d, ovf_d, unf_d;
`ifdef FPMULA_RNE_EN
  logic [2*MAN_W:0]       pn;
  logic                   round_up, carry;
`endif

  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    msb  = p2_q[2*MAN_W+1];
    es_n = es2_q + (msb ? ES_ONE : ES_ZERO);
`ifdef FPMULA_RNE_EN
    // Left-align the product so the mantissa, guard and sticky bits sit at
    // fixed positions whichever way it normalised.
    pn       = msb ? p2_q[2*MAN_W:0] : {p2_q[2*MAN_W-1:0], 1'b0};
    round_up = pn[MAN_W] & ((|pn[MAN_W-1:0]) | pn[MAN_W+1]);
    {carry, mant} = {1'b0, pn[2*MAN_W:MAN_W+1]} + (MAN_W+1)'(round_up);
    // A carry out means 1.11..1 rounded up to 10.00..0; the mantissa is already zero.
    if (carry) es_n = es_n + ES_ONE;
`else
    mant = msb ? p2_q[2*MAN_W:MAN_W+1] : p2_q[2*MAN_W-1:MAN_W];
`endif
    res_d = {s2_q, es_n[EXP_W-1:0], mant};
    exc_d = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (exc2_q) begin
      res_d = QNAN;
      exc_d = 1'b1;
      ovf_d = bexc2_q;
    end else if (zero2_q) begin
      res_d = {s2_q, {(W-1){1'b0}}};
    end else if (es_n >= ES_INF) begin
      res_d = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (es_n <= ES_ZERO) begin
      res_d = {s2_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  // NOTE: the datapath registers are reset as well as the valids, so reset
  // returns result/flags to zero and leaves no X in the pipeline.
  // NOTE: sequential state uses non-blocking assignments only. Every stage
  // then samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      a0_q        <= '0;
      b0_q        <= '0;
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      zero1_q     <= 1'b0;
      exc1_q      <= 1'b0;
      bexc1_q     <= 1'b0;
      es1_q       <= '0;
      ma1_q       <= '0;
      mb1_q       <= '0;
      v2_q        <= 1'b0;
      s2_q        <= 1'b0;
      zero2_q     <= 1'b0;
      exc2_q      <= 1'b0;
      bexc2_q     <= 1'b0;
      es2_q       <= '0;
      p2_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (!stall) begin
      v0_q    <= in_valid;
      a0_q    <= a_operand;
      b0_q    <= b_operand;
      v1_q    <= v0_q;
      s1_q    <= s1_d;
      zero1_q <= zero1_d;
      exc1_q  <= exc1_d;
      bexc1_q <= bexc1_d;
      es1_q   <= es1_d;
      ma1_q   <= ma1_d;
      mb1_q   <= mb1_d;
      v2_q    <= v1_q;
      s2_q    <= s1_q;
      zero2_q <= zero1_q;
      exc2_q  <= exc1_q;
      bexc2_q <= bexc1_q;
      es2_q   <= es1_q;
      p2_q    <= p2_d;
      out_valid_q <= v2_q;
      // Bubbles leave the last result and flags untouched.
      if (v2_q) begin
        result_q <= res_d;
        exc_q    <= exc_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign Exception = exc_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_fp_mult_approx_pipe.sv
// ---------------------------------------------------------------------------
// Self-checking bench for fp_mult_approx_pipe (binary32 layout, TRUNC=8).
// A second instance with TRUNC=0 serves the exact-mantissa case. Operand
// pairs are recorded when accepted and compared, in order, when the output
// transfers. The expected words come from directed constants or from an
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fp_mult_approx_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;

  typedef logic [W+2:0] exp_t;   // {Exception, Overflow, Underflow, result}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a_operand = '0;
  logic [W-1:0] b_operand = '0;
  logic         in_ready, out_valid, exc_o, ovf_o, unf_o;
  logic [W-1:0] result;
  logic         r0_in_ready, r0_out_valid, r0_exc, r0_ovf, r0_unf;
  logic [W-1:0] r0_result;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t cur_exp = '0;

  always #5 clk = ~clk;

  fp_mult_approx_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TRUNC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .Exception(exc_o),
    .Overflow(ovf_o), .Underflow(unf_o)
  );

  fp_mult_approx_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TRUNC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0_in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .out_valid(r0_out_valid),
    .out_ready(out_ready), .result(r0_result), .Exception(r0_exc),
    .Overflow(r0_ovf), .Underflow(r0_unf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the decoded fields.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int trunc);
    int     ea, eb, es;
    logic   s;
    longint ma, mb, p, mant, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (ea == 255 || eb == 255) return {1'b1, (ea == 255 && eb == 255), 1'b0, 32'h7FC0_0000};
    if (ea == 0 || eb == 0) return {3'b000, s, 31'd0};
    ma = ((longint'(a[22:0]) >> trunc) << trunc) + (longint'(1) << 23);
    mb = ((longint'(b[22:0]) >> trunc) << trunc) + (longint'(1) << 23);
    p  = ma * mb;
    es = ea + eb - 127;
    if (p >= (longint'(1) << 47)) begin
      mant = p >> 24;
      rem  = p % (longint'(1) << 24);
      half = longint'(1) << 23;
      es++;
    end else begin
      mant = p >> 23;
      rem  = p % (longint'(1) << 23);
      half = longint'(1) << 22;
    end
    mant = mant - (longint'(1) << 23);
`ifdef FPMULA_RNE_EN
    if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
    if (mant == (longint'(1) << 23)) begin
      mant = 0;
      es++;
    end
`else
    if (rem > half) mant = mant + 0;   // truncation: discarded bits are ignored
`endif
    if (es >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (es <= 0) return {3'b001, s, 31'd0};
    return {3'b000, s, es[7:0], mant[22:0]};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0:       x[30:23] = 8'h00;
      1:       x[30:23] = 8'hFF;
      default: x[30:23] = 8'($urandom_range(90, 165));
    endcase
    return x;
  endfunction

  // Scoreboard: record on acceptance, compare on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        check("output_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
          check("result_flags", 64'({exc_o, ovf_o, unf_o, result}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    logic acc;
    a_operand = a;
    b_operand = b;
    cur_exp   = e;
    in_valid  = 1'b1;
    acc       = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    check("issue_accepted", 64'(acc), 64'd1);
  endtask

  task automatic issue_rand();
    logic [W-1:0] a, b;
    a = rand_op();
    b = rand_op();
    issue(a, b, model(a, b, 8));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    logic         seen;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({exc_o, ovf_o, unf_o}), 64'd0);
    #20 rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: accepted at edge N, out_valid rises at edge N+3
    a_operand = 32'h4580_0000;
    b_operand = 32'h4580_0000;
    cur_exp   = {3'b000, 32'h4B80_0000};
    in_valid  = 1'b1;
    step();                     // edge N
    in_valid = 1'b0;
    check("lat_n0", 64'(out_valid), 64'd0);
    step();
    check("lat_n1", 64'(out_valid), 64'd0);
    step();
    check("lat_n2", 64'(out_valid), 64'd0);
    step();
    check("lat_n3", 64'(out_valid), 64'd1);
    check("lat_result", 64'(result), 64'h4B80_0000);
    check("lat_flags", 64'({exc_o, ovf_o, unf_o}), 64'd0);
    drain();

    // Directed vectors back to back, including the edge cases
    issue(32'h3FC0_0000, 32'h3FC0_0000, {3'b000, 32'h4010_0000});
    issue(32'h4000_0000, 32'hC040_0000, {3'b000, 32'hC0C0_0000});
    issue(32'h7F00_0000, 32'h7F00_0000, {3'b010, 32'h7F80_0000});
    issue(32'h0080_0000, 32'h0080_0000, {3'b001, 32'h0000_0000});
    issue(32'h7F80_0000, 32'h7F80_0000, {3'b110, 32'h7FC0_0000});
    issue(32'hC152_6666, 32'h0000_0000, {3'b000, 32'h8000_0000});
    issue(32'h3F80_00FF, 32'h3F80_0000, {3'b000, 32'h3F80_0000});
    in_valid = 1'b0;
    drain();

    // TRUNC=0 instance keeps the low mantissa bits
    issue(32'h3F80_00FF, 32'h3F80_0000, {3'b000, 32'h3F80_0000});
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = r0_out_valid;
    end
    check("exact_valid", 64'(seen), 64'd1);
    check("exact_result", 64'(r0_result), 64'h3F80_00FF);
    drain();

    // Backpressure: five ops in flight, output blocked for four cycles
    for (int i = 0; i < 5; i++) issue_rand();
    a_operand = rand_op();
    b_operand = rand_op();
    cur_exp   = model(a_operand, b_operand, 8);
    out_ready = 1'b0;
    #1;
    held = result;
    check("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hold", 64'(result), 64'(held));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain();

    // Randomised traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      a_operand = rand_op();
      b_operand = rand_op();
      cur_exp   = model(a_operand, b_operand, 8);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two operations in flight
    issue_rand();
    issue_rand();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    exp_q.delete();
    #10 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_idle", 64'(out_valid), 64'd0);
    end
    check("post_rst_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
